// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
// Frame layout: sync byte, length, payload, checksum.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_FRAME   = 2'b11;

  // States in which a frame is being received and the byte timer runs.
  function automatic logic in_frame(input state_t s);
    return (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/program_loader_byte_timer.sv
// Inter-byte watchdog: counts idle clocks while enabled and flags expiry
// on the clock where the count reaches TIMEOUT_CYC-1.
module byte_timer #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear || !enable) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/program_loader.sv
// Receives a framed program image from the UART and writes it into program
// memory while holding the CPU; restarts the CPU after a valid checksum.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_error,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);

  state_t            state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              cpu_restart_q, cpu_restart_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        remain_q, remain_d;
  logic [7:0]        sum_q, sum_d;

  logic              timer_enable;
  logic              timer_expired;
  logic [7:0]        sum_plus_byte;

  assign timer_enable  = in_frame(state_q);
  assign sum_plus_byte = sum_q + rx_data;

  byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_byte_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    // The address of a written byte is presented for one cycle, then advances.
    mem_addr_d    = mem_addr_q + ADDR_W'(mem_we_q);
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    cpu_restart_d = 1'b0;
    done_d        = done_q;
    err_code_d    = err_code_q;
    remain_d      = remain_q;
    sum_d         = sum_q;

    unique case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d    = SYNC;
          done_d     = 1'b0;
          err_code_d = ERR_NONE;
          mem_addr_d = '0;
        end
      end
      SYNC: begin
        if (!load_req) begin
          state_d = IDLE;
        end else if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = LEN;
        end
      end
      LEN: begin
        if (!load_req) begin
          state_d = IDLE;
        end else if (rx_error) begin
          state_d    = ERROR;
          err_code_d = ERR_FRAME;
        end else if (rx_valid) begin
          if (rx_data == 8'd0) begin
            state_d    = ERROR;
            err_code_d = ERR_FRAME;
          end else begin
            state_d  = DATA;
            remain_d = rx_data;
            sum_d    = 8'd0;
          end
        end else if (timer_expired) begin
          state_d    = ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      DATA: begin
        if (!load_req) begin
          state_d = IDLE;
        end else if (rx_error) begin
          state_d    = ERROR;
          err_code_d = ERR_FRAME;
        end else if (rx_valid) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = rx_data;
          sum_d       = sum_plus_byte;
          remain_d    = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            state_d = CSUM;
          end
        end else if (timer_expired) begin
          state_d    = ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      CSUM: begin
        if (!load_req) begin
          state_d = IDLE;
        end else if (rx_error) begin
          state_d    = ERROR;
          err_code_d = ERR_FRAME;
        end else if (rx_valid) begin
          if (sum_plus_byte == 8'd0) begin
            state_d       = DONE;
            done_d        = 1'b1;
            cpu_restart_d = 1'b1;
          end else begin
            state_d    = ERROR;
            err_code_d = ERR_CSUM;
          end
        end else if (timer_expired) begin
          state_d    = ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      DONE, ERROR: begin
        if (!load_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cpu_hold_d = (state_d != IDLE);
    busy_d     = in_frame(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 8'd0;
      cpu_hold_q    <= 1'b0;
      cpu_restart_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_code_q    <= ERR_NONE;
      remain_q      <= 8'd0;
      sum_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_hold_q    <= cpu_hold_d;
      cpu_restart_q <= cpu_restart_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_code_q    <= err_code_d;
      remain_q      <= remain_d;
      sum_q         <= sum_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_hold    = cpu_hold_q;
  assign cpu_restart = cpu_restart_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_code    = err_code_q;

endmodule

// File: doc/program_loader.md
# program_loader

Sequences a serial program download into the CPU's program memory. While the halt/load switch is asserted, it holds the CPU and parses framed bytes from the UART receiver. Each payload byte is written to consecutive program-memory addresses, and the frame checksum is verified. On success it releases the CPU with a one-cycle restart request. It sits between `UART_top` (receive side), the program memory write port and `cpu_top` control inputs, all on the same system clock.

## Interface
- `ADDR_W`, 8: program-memory address width.
- `TIMEOUT_CYC`, 1_000_000: maximum clocks between consecutive frame bytes after sync.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `load_req`  in  1  level; load mode requested (halt switch, pre-synchronised).
- `rx_data`  in  8  received byte; valid only with `rx_valid`.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `rx_error`  in  1  one-cycle UART framing/parity error strobe.
- `mem_we`  out  1  program-memory write enable, one cycle per byte.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  8  write data.
- `cpu_hold`  out  1  stalls the CPU while high.
- `cpu_restart`  out  1  one-cycle pulse; CPU resets its PC to 0.
- `busy`  out  1  frame in progress (states LEN/DATA/CSUM).
- `done`  out  1  last load succeeded.
- `err_code`  out  2  00 none, 01 checksum, 10 timeout, 11 framing.

## Operation
- Frame format: sync byte 0xA5, length N (1..255), N payload bytes, checksum C. The frame is valid when (sum of payload + C) mod 256 == 0. The length byte is not summed.
- State machine:
  - IDLE → SYNC when `load_req`=1. On this transition `done`←0, `err_code`←00 and the address counter←0.
  - SYNC: bytes ≠ 0xA5 are ignored; 0xA5 → LEN.
  - LEN: N=0 → ERROR with code 11; otherwise latch N and go to DATA.
  - DATA: each byte is written to memory at the current address, then the address increments. The 8-bit running sum accumulates each byte. After the Nth byte → CSUM.
  - CSUM: if sum+C == 0 → DONE, otherwise → ERROR with code 01.
  - DONE: `done`=1. `cpu_restart` pulses on the entry cycle. When `load_req`=0 → IDLE.
  - ERROR: `err_code` is held. When `load_req`=0 → IDLE.
- `cpu_hold` = 1 in every state except IDLE.
- `rx_valid` in IDLE, DONE or ERROR is ignored; no memory writes occur.
- `rx_error` in LEN, DATA or CSUM → ERROR with code 11. In SYNC it is ignored.
- `load_req` falling in SYNC, LEN, DATA or CSUM aborts to IDLE, with `err_code` left at 00. Memory already written stays written.
- Timeout: the byte timer clears on every `rx_valid` and counts in LEN, DATA and CSUM. Reaching TIMEOUT_CYC → ERROR with code 10.
- Address wraps modulo 2^ADDR_W. N=255 writes addresses 0..254.
- Simultaneous events, highest priority first:
  1. reset
  2. `load_req` drop
  3. `rx_error`
  4. `rx_valid`
  5. timeout

## Timing
- Reset (`rst`=0 at an edge) sets: IDLE, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `cpu_restart`=0, `busy`=0, `done`=0, `err_code`=00. Reset mid-frame discards all progress.
- All outputs are registered.
- `mem_we`/`mem_addr`/`mem_wdata` are valid the cycle after the `rx_valid` that delivered the byte. `mem_addr` then advances on the following edge.
- The state transition takes effect on the edge sampling `rx_valid`.
- `cpu_restart` is high for exactly one cycle, one cycle after the checksum byte's `rx_valid`. `done` rises the same cycle.
- `cpu_hold` rises one cycle after `load_req` is seen high. It falls one cycle after the IDLE transition.
- The timeout fires on the clock where the counter equals TIMEOUT_CYC−1.

## Structure
- Package `loader_pkg`: state enum (IDLE, SYNC, LEN, DATA, CSUM, DONE, ERROR), `SYNC_BYTE`=8'hA5, and `err_code` constants `ERR_NONE`/`ERR_CSUM`/`ERR_TIMEOUT`/`ERR_FRAME`.
- Sub-module `byte_timer` (parameter TIMEOUT_CYC; inputs `clear`, `enable`; output `expired`) holds the inter-byte counter.
- Everything else is one FSM plus datapath registers (address, remaining count, sum) in `program_loader`.

## Test plan
- Good frame: `load_req`=1, then bytes A5 03 10 20 30 A0 → writes 10@0, 20@1, 30@2. Then `done`=1, `cpu_restart` single pulse, `err_code`=00; `cpu_hold` drops after `load_req`=0.
- Bad checksum: A5 02 01 02 00 → writes 01@0, 02@1, then ERROR, `err_code`=01, no `cpu_restart`, `cpu_hold` stays high until `load_req`=0.
- Noise and zero length: bytes 00 FF A5 before the real frame → the leading bytes are ignored with no writes. Separately, A5 00 → `err_code`=11.
- Timeout: with TIMEOUT_CYC=16, A5 02 11 and then silence → ERROR, `err_code`=10, 16 cycles after byte 11.
- Abort and reset: `load_req` dropped after 2 of 4 payload bytes → IDLE, `err_code`=00, `cpu_hold`=0. `rst`=0 mid-DATA → all outputs at their reset values on the next cycle.
- Ignored input: `rx_valid` while IDLE → no `mem_we`. `rx_error` coincident with `rx_valid` in DATA → ERROR with code 11 and no write.
